// File: rtl/dsram_responder.sv
// dsram_responder -- data-side SRAM responder for the CPU data memory port.
//
// Accepts one load/store at a time through an addr_ok/data_ok handshake and
// returns a full aligned 32-bit word a fixed number of cycles after
// acceptance. Stores honour per-byte strobes; the response word of a store
// is the merged (post-write) word.
//
// Parameters:
//   ADDR_W   byte-address bits decoded (array depth 2^(ADDR_W-2) words), 4..20
//   LATENCY  cycles from acceptance to data_ok, 1..15
//
// Ports:
//   clk, resetn          clock; synchronous active-low reset
//   data_req             request valid
//   data_wr              1 = store, 0 = load
//   data_wstrb[3:0]      store byte enables (bit i -> wdata[8i+7:8i])
//   data_addr[31:0]      byte address; [1:0] and bits above ADDR_W-1 ignored
//   data_wdata[31:0]     store data
//   data_addr_ok         request accepted when data_req is also high
//   data_data_ok         one-cycle response strobe
//   data_rdata[31:0]     response word, valid with data_data_ok
//
// Build option:
//   DSRAM_RAND_DELAY_EN  adds a 4-bit LFSR; each accepted request gets an
//                        effective latency of LATENCY + lfsr[1:0].

// One byte lane of the storage array. Combinational read so the merged word
// can be captured on the same edge the write lands.
module dsram_byte_lane #(
  parameter int IDX_W = 14
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wbyte,
  output logic [7:0]       rbyte
);
  logic [7:0] mem [1<<IDX_W];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wbyte;
  end

  assign rbyte = mem[idx];
endmodule

module dsram_responder #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
);
  localparam int IDX_W     = ADDR_W - 2;
  localparam int NUM_LANES = 4;
  localparam int CNT_W     = 5;  // holds LATENCY+3 up to 18

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic             wr;
    logic [3:0]       wstrb;
    logic [31:0]      wdata;
    logic [IDX_W-1:0] idx;
  } req_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d, req_in, cur;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] lat_eff;
  logic             accept;
  logic             enter_resp;

  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] lane_rbyte;
  logic [NUM_LANES-1:0][7:0] lane_wbyte;
  logic [NUM_LANES-1:0][7:0] merged;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_addr[31:ADDR_W], data_addr[1:0]};

`ifdef DSRAM_RAND_DELAY_EN
  logic [3:0] lfsr_q, lfsr_d;

  // x^4+x^3+1, free-running
  always_comb lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};

  always_ff @(posedge clk) begin
    if (!resetn) lfsr_q <= 4'b1001;
    else         lfsr_q <= lfsr_d;
  end

  assign lat_eff = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
  assign lat_eff = CNT_W'(LATENCY);
`endif

  assign req_in = '{wr: data_wr, wstrb: data_wstrb, wdata: data_wdata,
                    idx: data_addr[ADDR_W-1:2]};

  assign data_addr_ok = (state_q != WAIT);
  assign data_data_ok = (state_q == RESP);
  assign data_rdata   = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    accept  = data_req && (state_q != WAIT);
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          req_d = req_in;
          if (lat_eff == CNT_W'(1)) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            state_d = WAIT;
            cnt_d   = lat_eff - CNT_W'(2);
          end
        end else if (state_q == RESP) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // The request served on the edge entering RESP: a latency-1 accept goes
  // straight to RESP, so its fields come from the port, not the latch.
  assign cur        = accept ? req_in : req_q;
  assign enter_resp = resetn && (state_d == RESP);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_we[i]    = enter_resp && cur.wr && cur.wstrb[i];
    assign lane_wbyte[i] = cur.wdata[8*i +: 8];
    assign merged[i]     = (cur.wr && cur.wstrb[i]) ? lane_wbyte[i] : lane_rbyte[i];

    dsram_byte_lane #(.IDX_W(IDX_W)) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .idx   (cur.idx),
      .wbyte (lane_wbyte[i]),
      .rbyte (lane_rbyte[i])
    );
  end

  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp) rdata_d = merged;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_dsram_responder.sv
// Testbench for dsram_responder: two instances (latency 1 and latency 3),
// a transaction-level reference model (pending request + due cycle, word
// memory with known-byte masks), a table of directed vectors, hand-written
// back-to-back and mid-operation reset sequences, and random traffic.
module tb_dsram_responder;
  localparam int ADDR_W = 16;
  localparam int L0 = 1;
  localparam int L1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn  [2];
  logic        req   [2];
  logic        wr    [2];
  logic [3:0]  strb  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        aok   [2];
  logic        dok   [2];
  logic [31:0] rdata [2];

  dsram_responder #(.ADDR_W(ADDR_W), .LATENCY(L0)) u_dut0 (
    .clk(clk), .resetn(rstn[0]), .data_req(req[0]), .data_wr(wr[0]),
    .data_wstrb(strb[0]), .data_addr(addr[0]), .data_wdata(wdata[0]),
    .data_addr_ok(aok[0]), .data_data_ok(dok[0]), .data_rdata(rdata[0]));

  dsram_responder #(.ADDR_W(ADDR_W), .LATENCY(L1)) u_dut1 (
    .clk(clk), .resetn(rstn[1]), .data_req(req[1]), .data_wr(wr[1]),
    .data_wstrb(strb[1]), .data_addr(addr[1]), .data_wdata(wdata[1]),
    .data_addr_ok(aok[1]), .data_data_ok(dok[1]), .data_rdata(rdata[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp,
                     input logic [31:0] mask = 32'hFFFF_FFFF);
    checks++;
    if (((act ^ exp) & mask) !== 32'h0) begin
      errors++;
      $display("FAIL %s actual=%h required=%h mask=%h t=%0t", nm, act, exp, mask, $time);
    end
  endtask

  function automatic int lat_of(input int s);
    return (s == 0) ? L0 : L1;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    bit          wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  bit          pend [2];
  int          due  [2];
  txn_t        ptx  [2];
  logic [31:0] mem  [int];
  logic [3:0]  kn   [int];

  function automatic int key(input int s, input logic [31:0] a);
    return (s << 20) | int'(a[ADDR_W-1:2]);
  endfunction

  task automatic mon_step(input int s);
    logic [31:0] w, mm;
    logic [3:0]  m;
    bit          exp_dok;
    int          k;
    if (!mon_en) return;
    exp_dok = pend[s] && (cyc == due[s]);
    chk($sformatf("data_ok%0d", s), {31'h0, dok[s]}, {31'h0, exp_dok});
    if (exp_dok) begin
      k = key(s, ptx[s].addr);
      w = mem.exists(k) ? mem[k] : 32'h0;
      m = kn.exists(k) ? kn[k] : 4'h0;
      if (ptx[s].wr) begin
        for (int b = 0; b < 4; b++)
          if (ptx[s].strb[b]) begin
            w[8*b +: 8] = ptx[s].wdata[8*b +: 8];
            m[b] = 1'b1;
          end
        mem[k] = w;
        kn[k]  = m;
      end
      for (int b = 0; b < 4; b++) mm[8*b +: 8] = {8{m[b]}};
      chk($sformatf("model_rdata%0d", s), rdata[s], w, mm);
      pend[s] = 0;
    end
    if (!rstn[s]) begin
      pend[s] = 0;
    end else begin
      chk($sformatf("addr_ok%0d", s), {31'h0, aok[s]}, {31'h0, !pend[s]});
      if (req[s] && !pend[s]) begin
        pend[s] = 1;
        due[s]  = cyc + lat_of(s);
        ptx[s]  = '{wr: wr[s], strb: strb[s], addr: addr[s], wdata: wdata[s]};
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  // ---------------- driver ----------------
  task automatic txn(input int s, input bit w, input logic [3:0] st, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output bit ok);
    bit acc = 0;
    ok = 0;
    rd = 32'h0;
    wr[s] = w; strb[s] = st; addr[s] = a; wdata[s] = d; req[s] = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = aok[s];
    end
    @(posedge clk); #1;
    req[s] = 1'b0;
    if (!acc) begin
      chk($sformatf("accept_timeout%0d", s), 32'h0, 32'h1);
      return;
    end
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (dok[s]) begin
        ok = 1;
        rd = rdata[s];
      end
    end
    if (!ok) chk($sformatf("resp_timeout%0d", s), 32'h0, 32'h1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] rd;
    bit ok;
    int nacc, nresp, first_c, last_c;
    logic [31:0] bb_exp [4];

    #1000000;
    $display("FAIL global_timeout t=%0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    bit ok, acc;
    int nacc, nresp, first_c, last_c;
    logic [31:0] bb_exp [4];

    vecs[0]  = '{1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1]  = '{0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h1122_3344};
    vecs[3]  = '{1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 32'h11BB_33DD};
    vecs[4]  = '{0, 4'h0, 32'h0000_0023, 32'h0,         32'h11BB_33DD};
    vecs[5]  = '{1, 4'hF, 32'h0001_0040, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
    vecs[6]  = '{0, 4'h0, 32'h0000_0040, 32'h0,         32'h5A5A_5A5A};
    vecs[7]  = '{1, 4'h0, 32'h0000_0010, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[8]  = '{0, 4'h0, 32'h0000_0012, 32'h0,         32'hDEAD_BEEF};
    vecs[9]  = '{1, 4'h8, 32'h0000_0021, 32'hFFFF_FFFF, 32'hFFBB_33DD};
    vecs[10] = '{1, 4'hF, 32'h0000_FFFC, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[11] = '{0, 4'h0, 32'h0003_FFFE, 32'h0,         32'hCAFE_F00D};

    for (int s = 0; s < 2; s++) begin
      rstn[s] = 1'b0; req[s] = 1'b0; wr[s] = 1'b0; strb[s] = 4'h0;
      addr[s] = 32'h0; wdata[s] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_addr_ok%0d", s), {31'h0, aok[s]}, 32'h1);
      chk($sformatf("rst_data_ok%0d", s), {31'h0, dok[s]}, 32'h0);
      chk($sformatf("rst_rdata%0d", s), rdata[s], 32'h0);
    end
    mon_en = 1;

    // directed vectors
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 12; i++) begin
        txn(s, vecs[i].wr, vecs[i].strb, vecs[i].addr, vecs[i].wdata, rd, ok);
        if (ok) chk($sformatf("vec%0d_dut%0d", i, s), rd, vecs[i].exp);
      end

    // back-to-back loads with data_req held high
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) begin
        bb_exp[i] = 32'h0100_0000 * (s + 1) + 32'h11 * i;
        txn(s, 1, 4'hF, 32'(4 * i), bb_exp[i], rd, ok);
      end
      nacc = 0; nresp = 0; first_c = 0; last_c = 0;
      wr[s] = 1'b0; strb[s] = 4'h0; addr[s] = 32'h0; req[s] = 1'b1;
      for (int c = 0; c < 60 && nresp < 4; c++) begin
        @(negedge clk);
        if (dok[s]) begin
          chk($sformatf("b2b%0d_word%0d", s, nresp), rdata[s], bb_exp[nresp]);
          if (nresp == 0) first_c = cyc;
          last_c = cyc;
          nresp++;
        end
        acc = req[s] && aok[s];
        @(posedge clk); #1;
        if (acc) begin
          nacc++;
          if (nacc < 4) addr[s] = 32'(4 * nacc);
          else          req[s]  = 1'b0;
        end
      end
      req[s] = 1'b0;
      chk($sformatf("b2b%0d_count", s), 32'(nresp), 32'd4);
      chk($sformatf("b2b%0d_span", s), 32'(last_c - first_c), 32'(3 * lat_of(s)));
      @(posedge clk); #1;
    end

    // mid-operation reset on the latency-3 instance: reset lands in the
    // last WAIT cycle, so the store must never reach the array
    txn(1, 1, 4'hF, 32'h8, 32'h0, rd, ok);
    wr[1] = 1'b1; strb[1] = 4'hF; addr[1] = 32'h8; wdata[1] = 32'hFFFF_FFFF; req[1] = 1'b1;
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = aok[1];
    end
    chk("midrst_accept", {31'h0, acc}, 32'h1);
    @(posedge clk); #1;   // T+1
    req[1] = 1'b0;
    @(posedge clk); #1;   // T+2
    rstn[1] = 1'b0;
    @(posedge clk); #1;   // T+3
    rstn[1] = 1'b1;
    chk("midrst_data_ok", {31'h0, dok[1]}, 32'h0);
    chk("midrst_rdata", rdata[1], 32'h0);
    chk("midrst_addr_ok", {31'h0, aok[1]}, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    txn(1, 0, 4'h0, 32'h8, 32'h0, rd, ok);
    if (ok) chk("midrst_load", rd, 32'h0);

    // random traffic; the model checks every cycle
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 150; i++) begin
        logic [31:0] a;
        a = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 2) |
            32'($urandom_range(0, 3));
        txn(s, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, rd, ok);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
